spi_config_responder: RTL

SPI_CONFIG_RESPONDER -- requirements
Module: spi_config_responder

---
 rtl/audio_cfg_pkg.sv | 12 +
 rtl/spi_config_responder_if.sv | 13 +
 rtl/spi_config_responder_sync2.sv | 13 +
 rtl/spi_config_responder.sv | 86 ++++++++
 4 files changed

// File: rtl/audio_cfg_pkg.sv
// audio_cfg_pkg: shared frame geometry, default reset address and FSM encoding for the config responder.
package audio_cfg_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 9;
  localparam int FRAME_BITS = 16;
  localparam logic [ADDR_W-1:0] RESET_ADDR_DEF = 7'h0F;
  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_COMMIT = 2'd2;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;
endpackage

// File: rtl/spi_config_responder_if.sv
// spi_config_responder_if: serial pins from the initiator plus the register-file/write-report outputs.
interface spi_config_responder_if import audio_cfg_pkg::*; #(parameter int NUM_REGS = 16);
  logic spi_sck;
  logic spi_mosi;
  logic cs;
  logic [NUM_REGS*DATA_W-1:0] regs;
  logic wr_stb;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic frame_err;
  modport master (output spi_sck, spi_mosi, cs, input regs, wr_stb, wr_addr, wr_data, frame_err);
  modport slave (input spi_sck, spi_mosi, cs, output regs, wr_stb, wr_addr, wr_data, frame_err);
endinterface

// File: rtl/spi_config_responder_sync2.sv
// sync2: two-flop synchronizer whose flops reset to the line's idle level.
module sync2 #(parameter logic RST_VAL = 1'b0) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) ff_q <= {2{RST_VAL}};
    else ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/spi_config_responder.sv
// spi_config_responder: oversampling SPI slave that decodes 16-bit {addr,data} frames into a 9-bit register file.
module spi_config_responder import audio_cfg_pkg::*; #(
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter logic [NUM_REGS*DATA_W-1:0] DEFAULTS = '0
) (
  input logic clk,
  input logic reset,
  spi_config_responder_if.slave bus
);
  localparam logic [4:0] CNT_MAX = 5'(FRAME_BITS + 1);
  logic sck_s, mosi_s, cs_s, sck_q, cs_q, armed_q, armed_d;
  logic [1:0] settle_q, state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic wr_stb_q, err_q;
  logic sck_rise, cs_fall, cs_rise, start, shift_en, commit, len_ok, rst_hit, wr_hit;
  frame_t fr;

  sync2 #(.RST_VAL(1'b0)) u_sck  (.clk(clk), .reset(reset), .d_i(bus.spi_sck),  .q_o(sck_s));
  sync2 #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .reset(reset), .d_i(bus.spi_mosi), .q_o(mosi_s));
  sync2 #(.RST_VAL(1'b1)) u_cs   (.clk(clk), .reset(reset), .d_i(bus.cs),       .q_o(cs_s));

  // A cs already low when reset releases belongs to an aborted frame: only arm once cs is really seen high.
  assign armed_d = armed_q | (&settle_q & cs_s);
  assign sck_rise = sck_s & ~sck_q;
  assign cs_fall = armed_q & cs_q & ~cs_s;
  assign cs_rise = cs_s & ~cs_q;
  assign start = state_q == S_IDLE && cs_fall;
  assign shift_en = state_q == S_SHIFT && sck_rise && !cs_s;
  assign commit = state_q == S_COMMIT;
  assign fr = frame_t'(sr_q);
  assign len_ok = cnt_q == 5'(FRAME_BITS);
  assign rst_hit = commit && len_ok && fr.addr == RESET_ADDR;
  assign wr_hit = commit && len_ok && !rst_hit && 32'(fr.addr) < NUM_REGS;

  always_comb begin
    state_d = state_q == S_IDLE ? (cs_fall ? S_SHIFT : S_IDLE) :
              state_q == S_SHIFT ? (cs_rise ? S_COMMIT : S_SHIFT) : S_IDLE;
    cnt_d = start ? '0 : (shift_en && cnt_q != CNT_MAX) ? cnt_q + 5'd1 : cnt_q;
    sr_d = start ? '0 : shift_en ? {sr_q[FRAME_BITS-2:0], mosi_s} : sr_q;
    wr_addr_d = (rst_hit || wr_hit) ? fr.addr : wr_addr_q;
    wr_data_d = (rst_hit || wr_hit) ? fr.data : wr_data_q;
    regs_d = rst_hit ? DEFAULTS : regs_q;
    for (int n = 0; n < NUM_REGS; n++)
      if (wr_hit && 32'(fr.addr) == n) regs_d[n*DATA_W +: DATA_W] = fr.data;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sck_q <= 1'b0;
      cs_q <= 1'b1;
      settle_q <= '0;
      armed_q <= 1'b0;
      state_q <= S_IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      regs_q <= DEFAULTS;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_stb_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sck_q <= sck_s;
      cs_q <= cs_s;
      settle_q <= {settle_q[0], 1'b1};
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      regs_q <= regs_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_stb_q <= rst_hit | wr_hit;
      err_q <= commit & ~(rst_hit | wr_hit);
    end

  assign bus.regs = regs_q;
  assign bus.wr_stb = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.frame_err = err_q;
endmodule
